// File: rtl/seg_pkg.sv
// Shared constants for the six-digit multiplexed 7-segment scanner:
// active-low segment codes, blanking values and FSM state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [5:0] SEL_OFF   = 6'h3F;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low 7-segment (g..a) decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg7
);

  always_comb begin
    seg7 = SEG_BLANK;
    case (hex)
      4'h0: seg7 = SEG_0;
      4'h1: seg7 = SEG_1;
      4'h2: seg7 = SEG_2;
      4'h3: seg7 = SEG_3;
      4'h4: seg7 = SEG_4;
      4'h5: seg7 = SEG_5;
      4'h6: seg7 = SEG_6;
      4'h7: seg7 = SEG_7;
      4'h8: seg7 = SEG_8;
      4'h9: seg7 = SEG_9;
      4'hA: seg7 = SEG_A;
      4'hB: seg7 = SEG_B;
      4'hC: seg7 = SEG_C;
      4'hD: seg7 = SEG_D;
      4'hE: seg7 = SEG_E;
      4'hF: seg7 = SEG_F;
      default: seg7 = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_dynamic_scan.sv
// Six-digit time-multiplexed 7-segment driver with per-slot blanking,
// leading-zero suppression and frame-synchronous data update.
module seg_dynamic_scan
  import seg_pkg::*;
#(
  parameter logic [31:0] CNT_SLOT = 32'd49_999,
  parameter logic [31:0] CNT_DEAD = 32'd99,
  parameter int          DIGITS   = 6
)(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic [23:0] data_in,
  input  logic [5:0]  dp_in,
  input  logic        lz_en,
  input  logic        data_vld,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_done
);

  logic [1:0]  state;
  logic [31:0] cnt;
  logic [2:0]  idx;
  logic [23:0] stage_data;
  logic [5:0]  stage_dp;
  logic        stage_lz;
  logic [23:0] act_data;
  logic [5:0]  act_dp;
  logic        act_lz;

  logic [3:0]  nibble;
  logic [6:0]  hex_code;
  logic [23:0] upper;
  logic        suppress;
  logic [7:0]  show_seg;
  logic        last_digit;

  // A digit is suppressed when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    nibble     = act_data[{idx, 2'b00} +: 4];
    upper      = act_data >> {idx, 2'b00};
    suppress   = act_lz && (idx != 3'd0) && (upper == 24'h0);
    show_seg   = {~act_dp[idx], suppress ? SEG_BLANK : hex_code};
    last_digit = (idx == 3'(DIGITS - 1));
  end

  seg_hex_decode u_hex_decode (
    .hex  (nibble),
    .seg7 (hex_code)
  );

  // A strobe landing on a frame-start edge bypasses staging so it shows in that frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      cnt        <= 32'd0;
      idx        <= 3'd0;
      stage_data <= 24'h0;
      stage_dp   <= 6'h0;
      stage_lz   <= 1'b0;
      act_data   <= 24'h0;
      act_dp     <= 6'h0;
      act_lz     <= 1'b0;
      sel        <= SEL_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (data_vld) begin
        stage_data <= data_in;
        stage_dp   <= dp_in;
        stage_lz   <= lz_en;
      end
      if (!en) begin
        state <= ST_IDLE;
        cnt   <= 32'd0;
        idx   <= 3'd0;
        sel   <= SEL_OFF;
        seg   <= SEG_OFF;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_BLANK;
            cnt      <= 32'd0;
            idx      <= 3'd0;
            sel      <= SEL_OFF;
            seg      <= SEG_OFF;
            act_data <= data_vld ? data_in : stage_data;
            act_dp   <= data_vld ? dp_in   : stage_dp;
            act_lz   <= data_vld ? lz_en   : stage_lz;
          end
          ST_BLANK: begin
            cnt <= cnt + 32'd1;
            if (cnt == CNT_DEAD) begin
              state <= ST_SHOW;
              sel   <= ~(6'b000001 << idx);
              seg   <= show_seg;
            end
          end
          ST_SHOW: begin
            if (cnt == CNT_SLOT) begin
              cnt   <= 32'd0;
              state <= ST_BLANK;
              sel   <= SEL_OFF;
              seg   <= SEG_OFF;
              if (last_digit) begin
                idx        <= 3'd0;
                frame_done <= 1'b1;
                act_data   <= data_vld ? data_in : stage_data;
                act_dp     <= data_vld ? dp_in   : stage_dp;
                act_lz     <= data_vld ? lz_en   : stage_lz;
              end else begin
                idx <= idx + 3'd1;
              end
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= 32'd0;
            idx   <= 3'd0;
            sel   <= SEL_OFF;
            seg   <= SEG_OFF;
          end
        endcase
      end
    end
  end

endmodule
